// File: rtl/control_unit.sv
// Instruction sequencer for the X/Y/Z datapath: expands one instruction per start
// pulse into registered Tx/Ty/Tz/sel_ula command cycles with a busy/done/err handshake.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] instr,
  input  logic [1:0] count,
  output logic [3:0] Tx,
  output logic [3:0] Ty,
  output logic [3:0] Tz,
  output logic [1:0] sel_ula,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] HOLD   = 4'b0000;
  localparam logic [3:0] LOAD   = 4'b0001;
  localparam logic [3:0] SHIFTR = 4'b0010;
  localparam logic [3:0] SHIFTL = 4'b0011;
  localparam logic [3:0] CLEAR  = 4'b0100;

  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_PASSX = 2'b10;
  localparam logic [1:0] ULA_PASSZ = 2'b11;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDX = 4'b0001;
  localparam logic [3:0] OP_LDY = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_ACC = 4'b0111;
  localparam logic [3:0] OP_CLR = 4'b1000;

  typedef enum logic [1:0] {IDLE, EXEC, STEP2, FIN} state_t;

  state_t     state, next_state;
  logic [3:0] op;
  logic [1:0] rep, next_rep;
  logic [3:0] tx_n, ty_n, tz_n;
  logic [1:0] sel_n;
  logic       busy_n, done_n, err_n;

  // Outputs are registered from the current state, so each command appears one
  // cycle after the state that requests it and is cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op      <= OP_NOP;
      rep     <= 2'd0;
      Tx      <= HOLD;
      Ty      <= HOLD;
      Tz      <= HOLD;
      sel_ula <= ULA_ADD;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= next_state;
      rep     <= next_rep;
      if (state == IDLE && start)
        op <= instr;
      Tx      <= tx_n;
      Ty      <= ty_n;
      Tz      <= tz_n;
      sel_ula <= sel_n;
      busy    <= busy_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

  always_comb begin
    next_state = state;
    next_rep   = rep;
    tx_n       = HOLD;
    ty_n       = HOLD;
    tz_n       = HOLD;
    sel_n      = ULA_ADD;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          next_rep   = count;
          next_state = EXEC;
        end
      end

      EXEC: begin
        busy_n = 1'b1;
        case (op)
          OP_LDX: tx_n = LOAD;
          OP_LDY: begin sel_n = ULA_PASSX; ty_n = LOAD; end
          OP_ADD: begin sel_n = ULA_ADD;   ty_n = LOAD; end
          OP_SUB: begin sel_n = ULA_SUB;   ty_n = LOAD; end
          OP_SHL: ty_n = SHIFTL;
          OP_SHR: ty_n = SHIFTR;
          OP_ACC: begin sel_n = ULA_ADD;   tz_n = LOAD; end
          OP_CLR: begin tx_n = CLEAR; ty_n = CLEAR; tz_n = CLEAR; end
          default: ;
        endcase

        // Shifts linger here so the same command repeats count+1 times.
        if ((op == OP_SHL || op == OP_SHR) && rep != 2'd0)
          next_rep = rep - 2'd1;
        else if (op == OP_ACC)
          next_state = STEP2;
        else
          next_state = FIN;
      end

      STEP2: begin
        busy_n     = 1'b1;
        sel_n      = ULA_PASSZ;
        ty_n       = LOAD;
        next_state = FIN;
      end

      FIN: begin
        busy_n     = 1'b1;
        done_n     = 1'b1;
        err_n      = (op > OP_CLR);
        next_state = IDLE;
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a small X/Y/Z register + ULA model that
// samples the command outputs on the falling edge, as the real datapath does.
module tb_control_unit;

  localparam logic [3:0] H  = 4'b0000;
  localparam logic [3:0] L  = 4'b0001;
  localparam logic [3:0] SR = 4'b0010;
  localparam logic [3:0] SL = 4'b0011;
  localparam logic [3:0] C  = 4'b0100;

  logic       clk, rst, start;
  logic [3:0] instr;
  logic [1:0] count;
  logic [3:0] Tx, Ty, Tz;
  logic [1:0] sel_ula;
  logic       busy, done, err;

  logic [3:0] bus, x, y, z, ula;
  int vectors, miscompares;

  control_unit dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .count(count),
    .Tx(Tx), .Ty(Ty), .Tz(Tz), .sel_ula(sel_ula),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: X loads from the bus, Y and Z load from the ULA result.
  always_comb begin
    case (sel_ula)
      2'b00:   ula = x + y;
      2'b01:   ula = y - x;
      2'b10:   ula = x;
      default: ula = z;
    endcase
  end

  always @(negedge clk) begin
    case (Tx)
      L: x <= bus;  SR: x <= x >> 1;  SL: x <= x << 1;  C: x <= 4'd0;
      default: ;
    endcase
    case (Ty)
      L: y <= ula;  SR: y <= y >> 1;  SL: y <= y << 1;  C: y <= 4'd0;
      default: ;
    endcase
    case (Tz)
      L: z <= ula;  SR: z <= z >> 1;  SL: z <= z << 1;  C: z <= 4'd0;
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] etx, ety, etz,
                             input logic [1:0] esel, input logic eb, ed, ee);
    logic [16:0] obs, exp;
    obs = {Tx, Ty, Tz, sel_ula, busy, done, err};
    exp = {etx, ety, etz, esel, eb, ed, ee};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got {Tx,Ty,Tz,sel,busy,done,err}=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkRegs(input string tag, input logic [11:0] exp);
    vectors++;
    assert ({x, y, z} === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got {X,Y,Z}=%h expected %h", tag, {x, y, z}, exp);
    end
  endtask

  // Pulse start for one edge, then scramble instr/count to show they are ignored while busy.
  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] cnt);
    start = 1'b1;
    instr = op;
    count = cnt;
    tick();
    start = 1'b0;
    instr = ~op;
    count = ~cnt;
  endtask

  task automatic runSingle(input string tag, input logic [3:0] op, input logic [3:0] etx, ety, etz,
                           input logic [1:0] esel, input logic ee);
    applyStimulus(op, 2'd0);
    tick();
    checkOutput({tag, "_cmd"}, etx, ety, etz, esel, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput({tag, "_done"}, H, H, H, 2'b00, 1'b1, 1'b1, ee);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0; instr = 4'd0; count = 2'd0; bus = 4'd0;
    x = 4'd0; y = 4'd0; z = 4'd0;

    tick();
    checkOutput("reset_hold", H, H, H, 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset landing mid-shift must clear the command before the falling edge.
    applyStimulus(4'b0110, 2'd3);
    tick();
    checkOutput("shr_before_rst", H, SR, H, 2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1 checkOutput("async_rst", H, H, H, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;

    applyStimulus(4'b1000, 2'd0);
    checkOutput("clr_edge0", H, H, H, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("clr_cmd", C, C, C, 2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("clr_done", H, H, H, 2'b00, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("clr_idle", H, H, H, 2'b00, 1'b0, 1'b0, 1'b0);

    // X=3, Y=4 then ADD gives Y=7.
    bus = 4'd4;  runSingle("ldx4", 4'b0001, L, H, H, 2'b00, 1'b0);
    runSingle("ldy", 4'b0010, H, L, H, 2'b10, 1'b0);
    bus = 4'd3;  runSingle("ldx3", 4'b0001, L, H, H, 2'b00, 1'b0);
    runSingle("add", 4'b0011, H, L, H, 2'b00, 1'b0);
    checkRegs("add_regs", {4'd3, 4'd7, 4'd0});

    runSingle("sub", 4'b0100, H, L, H, 2'b01, 1'b0);
    checkRegs("sub_regs", {4'd3, 4'd4, 4'd0});

    // Y=1 shifted left three times gives 1000.
    bus = 4'd1;  runSingle("ldx1", 4'b0001, L, H, H, 2'b00, 1'b0);
    runSingle("ldy1", 4'b0010, H, L, H, 2'b10, 1'b0);
    applyStimulus(4'b0101, 2'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("shl_cmd", H, SL, H, 2'b00, 1'b1, 1'b0, 1'b0);
    end
    tick();
    checkOutput("shl_done", H, H, H, 2'b00, 1'b1, 1'b1, 1'b0);
    checkRegs("shl_regs", {4'd1, 4'd8, 4'd0});

    // ACC with X=2, Y=5: Z=7 then Y=Z=7.
    bus = 4'd5;  runSingle("ldx5", 4'b0001, L, H, H, 2'b00, 1'b0);
    runSingle("ldy5", 4'b0010, H, L, H, 2'b10, 1'b0);
    bus = 4'd2;  runSingle("ldx2", 4'b0001, L, H, H, 2'b00, 1'b0);
    applyStimulus(4'b0111, 2'd0);
    tick();
    checkOutput("acc_step1", H, H, L, 2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("acc_step2", H, L, H, 2'b11, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("acc_done", H, H, H, 2'b00, 1'b1, 1'b1, 1'b0);
    checkRegs("acc_regs", {4'd2, 4'd7, 4'd7});

    runSingle("illegal", 4'b1101, H, H, H, 2'b00, 1'b1);
    checkRegs("illegal_regs", {4'd2, 4'd7, 4'd7});

    // A CLR start arriving mid-SHR must be dropped.
    applyStimulus(4'b0110, 2'd3);
    tick();
    checkOutput("shr_cmd0", H, SR, H, 2'b00, 1'b1, 1'b0, 1'b0);
    start = 1'b1; instr = 4'b1000;
    tick();
    checkOutput("shr_cmd1", H, SR, H, 2'b00, 1'b1, 1'b0, 1'b0);
    start = 1'b0; instr = 4'b0000;
    for (int i = 2; i < 4; i++) begin
      tick();
      checkOutput("shr_cmd", H, SR, H, 2'b00, 1'b1, 1'b0, 1'b0);
    end
    tick();
    checkOutput("shr_done", H, H, H, 2'b00, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("shr_no_clr", H, H, H, 2'b00, 1'b0, 1'b0, 1'b0);
    checkRegs("shr_regs", {4'd2, 4'd0, 4'd7});

    // Held start re-triggers NOP on every IDLE cycle: period of three cycles.
    start = 1'b1; instr = 4'b0000; count = 2'd0;
    tick();
    tick();
    checkOutput("retrig_cmd", H, H, H, 2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("retrig_done", H, H, H, 2'b00, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("retrig_idle", H, H, H, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("retrig_again", H, H, H, 2'b00, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
